// File: rtl/rx_ctrl_fsm.sv
// UART receive control FSM: sequences start/data/parity/stop bit timing
// and raises registered check strobes on the oversample check edge.
module rx_ctrl_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ERR_CHK
  } state_t;

  state_t     state;
  logic [5:0] presc_q;
  logic       par_en_q;
  logic       eob;
  logic       pre_chk;
  logic       counting;

  assign eob      = (edge_cnt == presc_q - 6'd1);
  // strobes are registered, so decode one edge before the check edge
  assign pre_chk  = (edge_cnt == {1'b0, presc_q[5:1]} + 6'd1);
  assign counting = (state != IDLE) && (state != ERR_CHK);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      presc_q     <= 6'd8;
      par_en_q    <= 1'b0;
      edge_cnt    <= 6'd0;
      bit_cnt     <= 4'd0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;

      if (counting) begin
        if (eob) begin
          edge_cnt <= 6'd0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          edge_cnt <= edge_cnt + 6'd1;
        end
      end

      unique case (state)
        IDLE: begin
          presc_q  <= Prescale;
          par_en_q <= PAR_EN;
          edge_cnt <= 6'd0;
          bit_cnt  <= 4'd0;
          if (!RX_IN) begin
            state       <= START;
            dat_samp_en <= 1'b1;
          end
        end
        START: begin
          strt_chk_en <= pre_chk;
          if (eob) begin
            if (strt_glitch) begin
              state       <= IDLE;
              bit_cnt     <= 4'd0;
              dat_samp_en <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          deser_en <= pre_chk;
          if (eob && bit_cnt == 4'd8)
            state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          par_chk_en <= pre_chk;
          if (eob)
            state <= STOP;
        end
        STOP: begin
          stp_chk_en <= pre_chk;
          if (eob) begin
            state       <= ERR_CHK;
            bit_cnt     <= 4'd0;
            dat_samp_en <= 1'b0;
          end
        end
        ERR_CHK: begin
          data_valid <= ~stp_err & ~(par_en_q & par_err);
          edge_cnt   <= 6'd0;
          bit_cnt    <= 4'd0;
          if (!RX_IN) begin
            state       <= START;
            dat_samp_en <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
// Directed bench for rx_ctrl_fsm: per-cycle expected output vectors
// for whole frames plus glitch, error, back-to-back and reset cases.
module tb_rx_ctrl_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;

  int ncmp = 0;
  int nerr = 0;
  int cyc;
  int n_deser, n_strt, n_par, n_stp, n_dv, n_dsen;

  rx_ctrl_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] obs_vec();
    return {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en,
            deser_en, par_chk_en, stp_chk_en, data_valid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_deser = 0; n_strt = 0; n_par = 0;
    n_stp = 0; n_dv = 0; n_dsen = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (deser_en) n_deser++;
    if (strt_chk_en) n_strt++;
    if (par_chk_en) n_par++;
    if (stp_chk_en) n_stp++;
    if (data_valid) n_dv++;
    if (dat_samp_en) n_dsen++;
  endtask

  // Precondition: the next edge sees the FSM in IDLE or ERR_CHK.
  // Runs start..ERR_CHK, checking the full output vector every cycle.
  task automatic frame(input int p, input bit pe, input logic [7:0] d,
                       input bit b2b, input bit dv0);
    logic        bits [0:10];
    int          nb, c, n, bi, ei;
    logic [15:0] e;
    nb = 10 + int'(pe);
    c  = p / 2 + 2;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = pe ? ^d : 1'b1;
    bits[10] = 1'b1;
    Prescale = 6'(p);
    PAR_EN   = pe;
    RX_IN    = 1'b0;
    cyc      = -1;
    for (int k = 0; k <= p * nb; k++) begin
      tick();
      bi = k / p;
      ei = k % p;
      if (k < p * nb)
        e = {6'(ei), 4'(bi), 1'b1, (k == c),
             (bi >= 1 && bi <= 8 && ei == c),
             (pe && bi == 9 && ei == c),
             (bi == nb - 1 && ei == c),
             (k == 0 && dv0)};
      else
        e = 16'h0;
      chk($sformatf("frame p=%0d k=%0d", p, k),
          32'(obs_vec()), 32'(e));
      n = k + 1;
      if (n < p * nb) RX_IN = bits[n / p];
      else RX_IN = !b2b;
      if (k == p) begin
        Prescale = (p == 8) ? 6'd32 : 6'd8;
        PAR_EN   = !pe;
      end
      if (k == p * nb) begin
        Prescale = 6'(p);
        PAR_EN   = pe;
      end
    end
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    cyc = 0;
    clr();
    repeat (3) tick();
    chk("reset_outs", 32'(obs_vec()), 32'h0);
    RST = 1'b0;
    repeat (3) tick();
    chk("idle_outs", 32'(obs_vec()), 32'h0);

    // P=8 with parity, clean checkers
    clr();
    frame(8, 1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    chk("s1_dv_c89", 32'(data_valid), 32'd1);
    chk("s1_n_strt", 32'(n_strt), 32'd1);
    chk("s1_n_deser", 32'(n_deser), 32'd8);
    chk("s1_n_par", 32'(n_par), 32'd1);
    chk("s1_n_stp", 32'(n_stp), 32'd1);
    repeat (2) tick();

    // P=16 without parity; par_err must be ignored
    clr();
    par_err = 1'b1;
    frame(16, 1'b0, 8'h3C, 1'b0, 1'b0);
    tick();
    chk("s2_dv", 32'(data_valid), 32'd1);
    chk("s2_n_par", 32'(n_par), 32'd0);
    chk("s2_n_deser", 32'(n_deser), 32'd8);
    par_err = 1'b0;
    repeat (2) tick();

    // false start
    clr();
    Prescale = 6'd8; PAR_EN = 1'b0;
    strt_glitch = 1'b1;
    RX_IN = 1'b0;
    cyc = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) RX_IN = 1'b1;
      chk($sformatf("glitch edge i=%0d", i), 32'(edge_cnt), 32'(i));
      chk($sformatf("glitch strt i=%0d", i),
          32'({dat_samp_en, strt_chk_en}), 32'({1'b1, (i == 6)}));
    end
    tick();
    chk("glitch_idle_c8", 32'(obs_vec()), 32'h0);
    repeat (10) tick();
    chk("glitch_n_deser", 32'(n_deser), 32'd0);
    chk("glitch_n_dsen", 32'(n_dsen), 32'd8);
    strt_glitch = 1'b0;

    // P=32 with stop error
    clr();
    stp_err = 1'b1;
    frame(32, 1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    chk("s4_dv", 32'(data_valid), 32'd0);
    repeat (4) tick();
    chk("s4_idle", 32'(obs_vec()), 32'h0);
    chk("s4_n_dv", 32'(n_dv), 32'd0);
    stp_err = 1'b0;

    // back-to-back frames
    clr();
    frame(8, 1'b0, 8'h81, 1'b1, 1'b0);
    frame(8, 1'b0, 8'h7E, 1'b0, 1'b1);
    tick();
    chk("b2b_dv2", 32'(data_valid), 32'd1);
    chk("b2b_n_dv", 32'(n_dv), 32'd2);
    repeat (2) tick();

    // reset mid-DATA
    clr();
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    cyc = -1;
    for (int i = 0; i <= 34; i++) begin
      tick();
      if (i == 7) RX_IN = 1'b1;
    end
    chk("rst_pre_bit", 32'(bit_cnt), 32'd4);
    chk("rst_pre_edge", 32'(edge_cnt), 32'd2);
    RST = 1'b1;
    tick();
    chk("rst_outs", 32'(obs_vec()), 32'h0);
    RST = 1'b0;
    clr();
    repeat (100) tick();
    chk("rst_no_dsen", 32'(n_dsen), 32'd0);
    chk("rst_no_dv", 32'(n_dv), 32'd0);

    // recovery frame after reset
    clr();
    frame(8, 1'b0, 8'h96, 1'b0, 1'b0);
    tick();
    chk("rec_dv", 32'(data_valid), 32'd1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
